dead_time_gen: RTL and testbench

- Downstream stage of the SPWM modulator. Consumes its six deglitched gate requests and drives the physical half-bridge gates.
- Each of the three legs runs an independent FSM that never drives g1 and g2 of one leg high together.
- Every complementary transition gets a programmable dead time, and illegal (both-on) requests are flagged.
- All outputs are registered; 48 MHz clock domain.

---
 rtl/dead_time_gen.sv | 183 ++++++++++++++++++
 tb/tb_dead_time_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module      : dead_time_gen
// Description : Three-leg half-bridge gate driver with programmable dead
//               time. Each leg runs an independent IDLE/DEAD/HI/LO FSM that
//               never drives g1 and g2 high together. Every complementary
//               transition is separated by DT clock cycles of both-off.
//               Illegal both-on requests are treated as OFF and flagged.
//               All outputs are registered.
//               Optional build macro DEAD_TIME_GEN_FAULT_LATCH_EN makes the
//               fault flags sticky (cleared by clear_fault) and forces all
//               legs off while any fault is latched.
// Revision    : 1.0 - initial release
// ============================================================================
module dead_time_gen #(
    parameter int DT    = 10,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [5:0] g_in,
    input  logic       clear_fault,
    output logic [5:0] g_out,
    output logic [2:0] dt_active,
    output logic [2:0] fault
);

    // ------------------------------------------------------------------------
    // Parameter legality: the counter must be able to hold DT-1 and DT >= 1.
    // ------------------------------------------------------------------------
    if ((DT < 1) || (DT > ((1 << CNT_W) - 1))) begin : g_bad_dt
        $error("dead_time_gen: DT=%0d outside legal range 1..%0d", DT, (1 << CNT_W) - 1);
    end

    // Counter reload value: DEAD lasts DT cycles counting DT-1 down to 0.
    localparam logic [CNT_W-1:0] C_DT_LOAD = CNT_W'(DT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } leg_state_t;

    // Per-leg illegal-request strobe (bit 2 = a, bit 1 = b, bit 0 = c).
    logic [2:0] w_ill;
    // Forces every leg into a reloaded DEAD state (enable low or latched fault).
    logic       w_force;
    logic [2:0] r_fault;

    // ------------------------------------------------------------------------
    // Per-leg FSM. Leg index i: 0 = c, 1 = b, 2 = a, so g1 sits at bit i+3
    // and g2 at bit i, matching the {g1_a,g1_b,g1_c,g2_a,g2_b,g2_c} order.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_leg
        logic             w_g1;
        logic             w_g2;
        logic             w_req_hi;
        logic             w_req_lo;
        leg_state_t       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_g1;
        logic             r_g2;
        logic             r_dt;

        assign w_g1     = g_in[i+3];
        assign w_g2     = g_in[i];
        assign w_req_hi = w_g1 & ~w_g2;
        assign w_req_lo = w_g2 & ~w_g1;
        assign w_ill[i] = w_g1 & w_g2;

        // Leg state, dead-time counter and registered gate/dead outputs.
        // Outputs are derived from the next state so a state change is
        // visible at the same edge it is taken.
        always_ff @(posedge clk) begin
            if (reset || w_force) begin
                r_state <= ST_DEAD;
                r_cnt   <= C_DT_LOAD;
                r_g1    <= 1'b0;
                r_g2    <= 1'b0;
                r_dt    <= 1'b1;
            end else begin
                r_g1 <= 1'b0;
                r_g2 <= 1'b0;
                r_dt <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        // Dead time already served: turn on immediately.
                        if (w_req_hi) begin
                            r_state <= ST_HI;
                            r_g1    <= 1'b1;
                        end else if (w_req_lo) begin
                            r_state <= ST_LO;
                            r_g2    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_HI: begin
                        if (w_req_hi) begin
                            r_state <= ST_HI;
                            r_g1    <= 1'b1;
                        end else begin
                            r_state <= ST_DEAD;
                            r_cnt   <= C_DT_LOAD;
                            r_dt    <= 1'b1;
                        end
                    end
                    ST_LO: begin
                        if (w_req_lo) begin
                            r_state <= ST_LO;
                            r_g2    <= 1'b1;
                        end else begin
                            r_state <= ST_DEAD;
                            r_cnt   <= C_DT_LOAD;
                            r_dt    <= 1'b1;
                        end
                    end
                    ST_DEAD: begin
                        // Request changes while counting are ignored; only
                        // the request present at expiry decides the exit.
                        if (r_cnt == '0) begin
                            if (w_req_hi) begin
                                r_state <= ST_HI;
                                r_g1    <= 1'b1;
                            end else if (w_req_lo) begin
                                r_state <= ST_LO;
                                r_g2    <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_state <= ST_DEAD;
                            r_cnt   <= r_cnt - 1'b1;
                            r_dt    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_DEAD;
                        r_cnt   <= C_DT_LOAD;
                        r_dt    <= 1'b1;
                    end
                endcase
            end
        end

        assign g_out[i+3]   = r_g1;
        assign g_out[i]     = r_g2;
        assign dt_active[i] = r_dt;
    end

`ifdef DEAD_TIME_GEN_FAULT_LATCH_EN
    // Sticky fault flags; a new illegal request on the clearing edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 3'b000;
        end else begin
            r_fault <= (clear_fault ? 3'b000 : r_fault) | w_ill;
        end
    end

    assign w_force = ~enable | (|r_fault);
`else
    logic w_unused_clear;

    // Fault pulses for one cycle after each illegal request is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 3'b000;
        end else begin
            r_fault <= w_ill;
        end
    end

    assign w_force        = ~enable;
    assign w_unused_clear = clear_fault;
`endif

    assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dead_time_gen
// Description : Directed checks of dead_time_gen (DT=10) plus randomised
//               invariant monitoring on DT=1 and DT=255 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dead_time_gen;

    localparam int DT = 10;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [5:0] g_in;
    logic       clear_fault;
    logic [5:0] g_out;
    logic [2:0] dt_active;
    logic [2:0] fault;

    logic       rnd_enable;
    logic [5:0] rnd_g;
    logic       rnd_clear;
    logic [5:0] g_r1;
    logic [5:0] g_r255;
    logic [2:0] dt_r1;
    logic [2:0] dt_r255;
    logic [2:0] fault_r1;
    logic [2:0] fault_r255;

    int n_checks;
    int n_errors;
    logic mon_on;
    logic [5:0] mon_prev [2];
    int         mon_off  [2][3];

    dead_time_gen #(.DT(DT), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .g_in(g_in),
        .clear_fault(clear_fault), .g_out(g_out), .dt_active(dt_active), .fault(fault)
    );

    dead_time_gen #(.DT(1), .CNT_W(8)) u_dt1 (
        .clk(clk), .reset(reset), .enable(rnd_enable), .g_in(rnd_g),
        .clear_fault(rnd_clear), .g_out(g_r1), .dt_active(dt_r1), .fault(fault_r1)
    );

    dead_time_gen #(.DT(255), .CNT_W(8)) u_dt255 (
        .clk(clk), .reset(reset), .enable(rnd_enable), .g_in(rnd_g),
        .clear_fault(rnd_clear), .g_out(g_r255), .dt_active(dt_r255), .fault(fault_r255)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] mon_g(input int d);
        return (d == 0) ? g_r1 : g_r255;
    endfunction

    function automatic int mon_dt(input int d);
        return (d == 0) ? 1 : 255;
    endfunction

    // Exclusion on every cycle and >=DT both-off samples before any rise.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) begin
                    check("excl", 32'(mon_g(d)[k] & mon_g(d)[k+3]), 32'd0);
                    if ((mon_g(d)[k+3] & ~mon_prev[d][k+3]) | (mon_g(d)[k] & ~mon_prev[d][k]))
                        check("gap_ge_dt", 32'(mon_off[d][k] >= mon_dt(d)), 32'd1);
                    if (mon_g(d)[k] | mon_g(d)[k+3])
                        mon_off[d][k] <= 0;
                    else if (mon_off[d][k] < 100000)
                        mon_off[d][k] <= mon_off[d][k] + 1;
                end
                mon_prev[d] <= mon_g(d);
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        mon_on      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mon_prev[d] = 6'b0;
            for (int k = 0; k < 3; k++) mon_off[d][k] = 0;
        end
        reset       = 1'b1;
        enable      = 1'b1;
        g_in        = 6'b100000;
        clear_fault = 1'b0;
        rnd_enable  = 1'b1;
        rnd_g       = 6'b0;
        rnd_clear   = 1'b0;

        // Reset state, then release with leg a requesting HI.
        step();
        step();
        check("rst_g_out", 32'(g_out), 32'h00);
        check("rst_dt", 32'(dt_active), 32'h7);
        check("rst_fault", 32'(fault), 32'h0);
        reset  = 1'b0;
        mon_on = 1'b1;
        for (int k = 1; k < DT; k++) begin
            step();
            check("t1_hold_off", 32'(g_out), 32'h00);
            check("t1_dt_a", 32'(dt_active[2]), 32'd1);
        end
        step();
        check("t1_rise", 32'(g_out), 32'h20);
        check("t1_dt_fall", 32'(dt_active), 32'h0);

        // Leg a HI -> LO: immediate drop, LO after DT cycles.
        g_in = 6'b000100;
        step();
        check("t2_drop", 32'(g_out), 32'h00);
        check("t2_dt", 32'(dt_active), 32'h4);
        for (int k = 1; k < DT; k++) begin
            step();
            check("t2_off", 32'(g_out), 32'h00);
            check("t2_dt_a", 32'(dt_active[2]), 32'd1);
        end
        step();
        check("t2_lo_on", 32'(g_out), 32'h04);
        check("t2_dt_end", 32'(dt_active), 32'h0);

        // Leg b: 3-cycle HI, 3-cycle LO, then OFF; LO never reaches the gate.
        g_in = 6'b010100;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_b_hi", 32'(g_out), 32'h14);
        end
        g_in = 6'b000110;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_b_dead_lo", 32'(g_out), 32'h04);
            check("t3_b_dt", 32'(dt_active[1]), 32'd1);
        end
        g_in = 6'b000100;
        for (int k = 3; k < DT; k++) begin
            step();
            check("t3_b_dead_off", 32'(g_out), 32'h04);
            check("t3_b_dt", 32'(dt_active[1]), 32'd1);
        end
        step();
        check("t3_b_idle", 32'(g_out), 32'h04);
        check("t3_b_dt_end", 32'(dt_active), 32'h0);

        // Leg c LO, then one illegal both-on cycle.
        g_in = 6'b000101;
        step();
        check("t4_c_lo", 32'(g_out), 32'h05);
        g_in = 6'b001101;
        step();
        check("t4_c_drop", 32'(g_out), 32'h04);
        check("t4_fault", 32'(fault), 32'h1);
        g_in = 6'b000101;
`ifdef DEAD_TIME_GEN_FAULT_LATCH_EN
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_latched_off", 32'(g_out), 32'h00);
            check("t4_fault_held", 32'(fault), 32'h1);
        end
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("t4_fault_clr", 32'(fault), 32'h0);
        check("t4_clr_off", 32'(g_out), 32'h00);
        for (int k = 1; k < DT; k++) begin
            step();
            check("t4_resume_off", 32'(g_out), 32'h00);
        end
        step();
        check("t4_resume_on", 32'(g_out), 32'h05);
`else
        step();
        check("t4_fault_pulse", 32'(fault), 32'h0);
        check("t4_a_kept", 32'(g_out), 32'h04);
        for (int k = 3; k <= DT; k++) begin
            step();
            check("t4_c_dead", 32'(g_out), 32'h04);
        end
        step();
        check("t4_c_lo_again", 32'(g_out), 32'h05);
`endif

        // All legs HI, then enable low for 5 cycles.
        g_in = 6'b111000;
        for (int k = 0; k < DT + 2; k++) step();
        check("t5_all_hi", 32'(g_out), 32'h38);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t5_dis_off", 32'(g_out), 32'h00);
            check("t5_dis_dt", 32'(dt_active), 32'h7);
        end
        enable = 1'b1;
        for (int k = 1; k < DT; k++) begin
            step();
            check("t5_en_wait", 32'(g_out), 32'h00);
        end
        step();
        check("t5_en_on", 32'(g_out), 32'h38);

        // Reset while legs are on.
        reset = 1'b1;
        step();
        check("t6_rst_g", 32'(g_out), 32'h00);
        check("t6_rst_dt", 32'(dt_active), 32'h7);
        check("t6_rst_fault", 32'(fault), 32'h0);
        reset = 1'b0;

        // Random requests on the DT=1 and DT=255 instances.
        begin
            int cyc;
            cyc = 0;
            while (cyc < 20000) begin
                int hold;
                hold       = $urandom_range(1, 300);
                rnd_g      = 6'($urandom);
                rnd_enable = ($urandom_range(0, 15) != 0);
                for (int h = 0; h < hold; h++) begin
                    rnd_clear = ($urandom_range(0, 7) == 0);
                    step();
                    cyc++;
                end
            end
        end
        mon_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
